// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boots, fetches from instruction memory with an
// ack handshake, executes with stall/redirect/halt handling, and counts
// retired instructions with an 8-bit saturating counter.
//
// state  | meaning
// -------+----------------------------------------------------------------
// BOOT   | one idle cycle after reset release, no fetch request
// FETCH  | imem_req asserted, waits for imem_ack, pc held
// EXEC   | instruction in execute; on non-stalled cycle retire + next pc
// HALTED | frozen until reset; no requests, pc and retired held

module pc_sequencer #(
  parameter int unsigned          PC_W     = 5,
  parameter logic [PC_W-1:0]      RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            halt,
  output logic [PC_W-1:0] pc,
  output logic            instr_valid,
  output logic [1:0]      state,
  output logic [7:0]      retired
);

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    FETCH  = 2'b01,
    EXEC   = 2'b10,
    HALTED = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      retired_q, retired_d;
  logic            retire;

  // State, pc and retire counter registers; reset is asynchronous so a
  // pending fetch is dropped in the same cycle reset rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      retired_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, next-pc and handshake outputs; redirect inputs only matter
  // on a non-stalled EXEC cycle.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    retire      = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = EXEC;
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          retire = 1'b1;
          // jump outranks branch; otherwise fall through with natural wrap
          if (jump)              pc_d = jump_target;
          else if (branch_taken) pc_d = branch_target;
          else                   pc_d = pc_q + PC_W'(1);
          state_d = halt ? HALTED : FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Retire counter saturates rather than wrapping.
  always_comb begin
    retired_d = retired_q;
    if (retire && (retired_q != 8'hFF)) retired_d = retired_q + 8'd1;
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign state     = state_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int PC_W = 5;

  logic            clk;
  logic            rst;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            jump;
  logic [PC_W-1:0] jump_target;
  logic            halt;
  logic [PC_W-1:0] pc;
  logic            instr_valid;
  logic [1:0]      state;
  logic [7:0]      retired;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.PC_W(PC_W), .RESET_PC(5'd0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .halt(halt),
    .pc(pc), .instr_valid(instr_valid), .state(state), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full observable snapshot: state, pc, retired, imem_req, instr_valid, imem_addr
  task automatic snap(input string tag, input logic [1:0] st, input logic [4:0] p,
                      input logic [7:0] r, input logic req, input logic iv);
    chk({tag, ".state"},   32'(state),       32'(st));
    chk({tag, ".pc"},      32'(pc),          32'(p));
    chk({tag, ".retired"}, 32'(retired),     32'(r));
    chk({tag, ".req"},     32'(imem_req),    32'(req));
    chk({tag, ".iv"},      32'(instr_valid), 32'(iv));
    chk({tag, ".addr"},    32'(imem_addr),   32'(p));
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; halt = 1'b0;
    #3;
    snap("rst_async", 2'b00, 5'd0, 8'd0, 1'b0, 1'b0);
    tick(); tick();
    snap("rst_held", 2'b00, 5'd0, 8'd0, 1'b0, 1'b0);

    // release; ack tied high
    rst = 1'b0; imem_ack = 1'b1;
    snap("boot", 2'b00, 5'd0, 8'd0, 1'b0, 1'b0);
    tick(); snap("f0", 2'b01, 5'd0, 8'd0, 1'b1, 1'b0);
    tick(); snap("e0", 2'b10, 5'd0, 8'd0, 1'b0, 1'b1);
    tick(); snap("f1", 2'b01, 5'd1, 8'd1, 1'b1, 1'b0);
    tick(); snap("e1", 2'b10, 5'd1, 8'd1, 1'b0, 1'b1);
    tick(); snap("f2", 2'b01, 5'd2, 8'd2, 1'b1, 1'b0);

    // ack held low three cycles
    imem_ack = 1'b0;
    tick(); snap("wait1", 2'b01, 5'd2, 8'd2, 1'b1, 1'b0);
    tick(); snap("wait2", 2'b01, 5'd2, 8'd2, 1'b1, 1'b0);
    tick(); snap("wait3", 2'b01, 5'd2, 8'd2, 1'b1, 1'b0);
    imem_ack = 1'b1;
    tick(); snap("e2", 2'b10, 5'd2, 8'd2, 1'b0, 1'b1);

    // jump to 5
    jump = 1'b1; jump_target = 5'd5;
    tick(); snap("j5", 2'b01, 5'd5, 8'd3, 1'b1, 1'b0);
    jump = 1'b0;
    tick(); snap("e5", 2'b10, 5'd5, 8'd3, 1'b0, 1'b1);

    // jump beats branch
    jump = 1'b1; jump_target = 5'd20; branch_taken = 1'b1; branch_target = 5'd9;
    tick(); snap("prio", 2'b01, 5'd20, 8'd4, 1'b1, 1'b0);
    jump = 1'b0; branch_taken = 1'b0;
    tick(); snap("e20", 2'b10, 5'd20, 8'd4, 1'b0, 1'b1);

    // branch only
    branch_taken = 1'b1; branch_target = 5'd9;
    tick(); snap("br9", 2'b01, 5'd9, 8'd5, 1'b1, 1'b0);
    branch_taken = 1'b0;
    tick(); snap("e9", 2'b10, 5'd9, 8'd5, 1'b0, 1'b1);

    // go to 31, then wrap
    jump = 1'b1; jump_target = 5'd31;
    tick(); snap("j31", 2'b01, 5'd31, 8'd6, 1'b1, 1'b0);
    jump = 1'b0;
    tick(); snap("e31", 2'b10, 5'd31, 8'd6, 1'b0, 1'b1);
    tick(); snap("wrap", 2'b01, 5'd0, 8'd7, 1'b1, 1'b0);
    tick(); snap("e0b", 2'b10, 5'd0, 8'd7, 1'b0, 1'b1);

    // stall two cycles with redirect/halt asserted: all ignored
    stall = 1'b1; jump = 1'b1; jump_target = 5'd17; halt = 1'b1;
    tick(); snap("stall1", 2'b10, 5'd0, 8'd7, 1'b0, 1'b1);
    tick(); snap("stall2", 2'b10, 5'd0, 8'd7, 1'b0, 1'b1);
    stall = 1'b0; jump = 1'b0; halt = 1'b0;
    tick(); snap("unstall", 2'b01, 5'd1, 8'd8, 1'b1, 1'b0);

    // redirect/halt in FETCH have no effect
    imem_ack = 1'b0; jump = 1'b1; jump_target = 5'd20; halt = 1'b1; branch_taken = 1'b1;
    tick(); snap("fetch_ign", 2'b01, 5'd1, 8'd8, 1'b1, 1'b0);
    imem_ack = 1'b1; jump = 1'b0; halt = 1'b0; branch_taken = 1'b0;
    tick(); snap("e1b", 2'b10, 5'd1, 8'd8, 1'b0, 1'b1);

    // jump to 7, then halt there
    jump = 1'b1; jump_target = 5'd7;
    tick(); snap("j7", 2'b01, 5'd7, 8'd9, 1'b1, 1'b0);
    jump = 1'b0;
    tick(); snap("e7", 2'b10, 5'd7, 8'd9, 1'b0, 1'b1);
    halt = 1'b1;
    tick(); snap("halt", 2'b11, 5'd8, 8'd10, 1'b0, 1'b0);
    halt = 1'b0; jump = 1'b1; jump_target = 5'd3;
    tick(); snap("halted1", 2'b11, 5'd8, 8'd10, 1'b0, 1'b0);
    tick(); snap("halted2", 2'b11, 5'd8, 8'd10, 1'b0, 1'b0);
    jump = 1'b0;

    // asynchronous reset mid-cycle from HALTED
    #2 rst = 1'b1;
    #1 snap("rst_mid", 2'b00, 5'd0, 8'd0, 1'b0, 1'b0);
    tick(); tick();
    snap("rst_hold", 2'b00, 5'd0, 8'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); snap("f_after", 2'b01, 5'd0, 8'd0, 1'b1, 1'b0);

    // reset during a pending fetch: request drops at once, ack discarded
    imem_ack = 1'b0;
    tick(); snap("pend", 2'b01, 5'd0, 8'd0, 1'b1, 1'b0);
    #2 rst = 1'b1; imem_ack = 1'b1;
    #1 snap("rst_fetch", 2'b00, 5'd0, 8'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick(); snap("reboot", 2'b01, 5'd0, 8'd0, 1'b1, 1'b0);

    // saturation: 255 retirements, then two more
    for (int i = 0; i < 255; i++) begin
      tick(); tick();
    end
    snap("sat255", 2'b01, 5'd31, 8'd255, 1'b1, 1'b0);
    tick(); tick();
    tick(); tick();
    snap("sat_hold", 2'b01, 5'd1, 8'd255, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: PC_W, default 5, program-counter width in bits.
REQ-002 Parameter: RESET_PC, default 0, PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 imem_req  output  1  instruction-fetch request to instruction memory.
REQ-006 imem_addr  output  PC_W  fetch address, always equal to pc.
REQ-007 imem_ack  input  1  instruction-memory acknowledge; fetch completes in any cycle where imem_req and imem_ack are both 1.
REQ-008 stall  input  1  execute-stage hold request.
REQ-009 branch_taken  input  1  conditional branch resolved taken, sampled in EXEC.
REQ-010 branch_target  input  PC_W  branch destination.
REQ-011 jump  input  1  unconditional jump, sampled in EXEC.
REQ-012 jump_target  input  PC_W  jump destination.
REQ-013 halt  input  1  stop request, sampled in EXEC.
REQ-014 pc  output  PC_W  current program counter (registered).
REQ-015 instr_valid  output  1  fetched instruction is in execute this cycle.
REQ-016 state  output  2  FSM state: BOOT=00, FETCH=01, EXEC=10, HALTED=11.
REQ-017 retired  output  8  count of completed EXEC cycles.

Function
REQ-018 BOOT: one cycle after reset release, imem_req=0; unconditionally -> FETCH.
REQ-019 FETCH: imem_req=1 combinationally; stay in FETCH, pc held, while imem_ack=0; on imem_ack=1 -> EXEC next edge.
REQ-020 EXEC: instr_valid=1, imem_req=0; if stall=1 remain in EXEC, pc held, no retire, redirect/halt inputs ignored.
REQ-021 EXEC with stall=0: retired increments by 1, saturating at 255; next state FETCH unless halt=1.
REQ-022 EXEC next-PC priority (stall=0): jump -> jump_target; else branch_taken -> branch_target; else pc+1.
REQ-023 pc+1 is modulo 2^PC_W: pc=all-ones wraps to 0.
REQ-024 halt=1 in EXEC with stall=0: pc still updates per REQ-022, retired increments, next state HALTED.
REQ-025 HALTED: imem_req=0, instr_valid=0, pc and retired frozen; exit only via rst.
REQ-026 instr_valid is 1 only in EXEC; imem_req is 1 only in FETCH.
REQ-027 imem_addr is pc on every cycle, including BOOT and HALTED.
REQ-028 Inputs redirect only in EXEC; branch_taken, jump, halt in other states have no effect.

Reset
REQ-029 rst=1 asynchronously forces state=BOOT, pc=RESET_PC, retired=0, within the same cycle, regardless of state.
REQ-030 Reset mid-fetch (imem_req=1, ack pending) drops imem_req immediately; the pending ack is discarded.
REQ-031 While rst=1 held, outputs remain at reset values; sequencing resumes from BOOT on the first edge after release.

Verification
REQ-032 Reset, then imem_ack tied 1: state BOOT->FETCH->EXEC->FETCH; pc 0,0,0,1,1,2; retired increments every EXEC.
REQ-033 FETCH with imem_ack low 3 cycles: imem_req stays 1, pc constant, EXEC entered the edge after ack=1.
REQ-034 pc=5 in EXEC, jump=1 jump_target=20 and branch_taken=1 branch_target=9: next pc=20; branch only: next pc=9.
REQ-035 pc=31 (PC_W=5), no redirect: next pc=0; stall=1 for 2 EXEC cycles: pc, retired unchanged, instr_valid stays 1.
REQ-036 halt=1 in EXEC at pc=7: pc=8, state=11, imem_req=0 thereafter; rst mid-run: pc=RESET_PC, retired=0 asynchronously.
REQ-037 retired at 255 with further EXEC cycles: remains 255.
